// File: rtl/id_ex_pipe_reg.sv
// ID-to-EX pipeline register: LANES-wide beats, 2-entry skid, flush, preserved copy.
// Optional ID_EX_PERF_CNT_EN adds stall/bubble counters.
module id_ex_pipe_reg #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 96,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  input  logic [LANES*PC_W-1:0]      in_pc,
  input  logic [LANES*INSTR_W-1:0]   in_instr,
  input  logic [LANES-1:0]           in_order,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  output logic [LANES*PC_W-1:0]      out_pc,
  output logic [LANES-1:0]           out_order,
  input  logic                       out_ready,
  output logic [LANES*PC_W-1:0]      pres_pc,
  output logic [LANES*INSTR_W-1:0]   pres_instr,
  output logic [LANES-1:0]           pres_order,
  output logic [1:0]                 occupancy
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LANES-1:0]           h_lv, s_lv;
  logic [LANES*PAYLOAD_W-1:0] h_pay, s_pay;
  logic [LANES*PC_W-1:0]      h_pc, s_pc;
  logic [LANES*INSTR_W-1:0]   h_instr, s_instr;
  logic [LANES-1:0]           h_ord, s_ord;

  logic accept, drain;
  logic ld_hin, ld_hsk, ld_sk;

  assign accept = in_valid & in_ready & (|in_lane_valid);
  assign drain  = out_valid & out_ready;

  assign out_valid      = (state_q != EMPTY);
  assign out_lane_valid = h_lv;
  assign out_payload    = h_pay;
  assign out_pc         = h_pc;
  assign out_order      = h_ord;
  assign occupancy      = state_q;

  always_comb begin
    state_d = state_q;
    ld_hin  = 1'b0;
    ld_hsk  = 1'b0;
    ld_sk   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          ld_hin  = 1'b1;
        end
      end
      HALF: begin
        if (accept && drain) begin
          ld_hin = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          ld_sk   = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = HALF;
          ld_hsk  = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops every held beat and any beat offered this cycle
    if (flush) begin
      state_d = EMPTY;
      ld_hin  = 1'b0;
      ld_hsk  = 1'b0;
      ld_sk   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      in_ready   <= 1'b1;
      h_lv       <= '0;
      h_pay      <= '0;
      h_pc       <= '0;
      h_instr    <= '0;
      h_ord      <= '0;
      s_lv       <= '0;
      s_pay      <= '0;
      s_pc       <= '0;
      s_instr    <= '0;
      s_ord      <= '0;
      pres_pc    <= '0;
      pres_instr <= '0;
      pres_order <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
      if (ld_hin) begin
        h_lv    <= in_lane_valid;
        h_pay   <= in_payload;
        h_pc    <= in_pc;
        h_instr <= in_instr;
        h_ord   <= in_order;
      end else if (ld_hsk) begin
        h_lv    <= s_lv;
        h_pay   <= s_pay;
        h_pc    <= s_pc;
        h_instr <= s_instr;
        h_ord   <= s_ord;
      end
      if (ld_sk) begin
        s_lv    <= in_lane_valid;
        s_pay   <= in_payload;
        s_pc    <= in_pc;
        s_instr <= in_instr;
        s_ord   <= in_order;
      end
      // A drain is delivered even when flushed in the same cycle
      if (drain) begin
        for (int i = 0; i < LANES; i++) begin
          if (h_lv[i]) begin
            pres_pc[i*PC_W +: PC_W]          <= h_pc[i*PC_W +: PC_W];
            pres_instr[i*INSTR_W +: INSTR_W] <= h_instr[i*INSTR_W +: INSTR_W];
            pres_order[i]                    <= h_ord[i];
          end
        end
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!out_valid && perf_bubble_cnt != 32'hFFFF_FFFF)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
